led_mode_ctrl: RTL and testbench

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_mode_ctrl_pkg.sv | 26 ++
 rtl/led_mode_ctrl_key_debounce.sv | 44 ++++
 rtl/led_mode_ctrl.sv | 67 ++++++
 tb/tb_led_mode_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/led_mode_ctrl_pkg.sv
// Shared LED definitions: pattern codes seen by the LED driver and the
// mode controller's state encodings.
package led_mode_ctrl_pkg;

  localparam logic [2:0] MODE_HOLD = 3'h0;
  localparam logic [2:0] MODE_FAST = 3'h1;
  localparam logic [2:0] MODE_SLOW = 3'h2;
  localparam logic [2:0] MODE_ON   = 3'h3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SUCCESS = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TEST    = 2'd3;

  localparam int TMR_W = 28;

  // MODE_HOLD is reserved for the driver and never produced here.
  function automatic logic [2:0] mode_of(input logic [1:0] st);
    case (st)
      ST_SUCCESS:       mode_of = MODE_SLOW;
      ST_FAIL, ST_TEST: mode_of = MODE_FAST;
      default:          mode_of = MODE_ON;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_ctrl_key_debounce.sv
// Push-button front end: 2-flop synchronizer, stability debouncer and
// falling-edge detect producing a one-cycle press pulse.
module key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic press
);

  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          s1, s2;
  logic          lvl, lvl_d;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      lvl   <= 1'b1;
      lvl_d <= 1'b1;
      cnt   <= '0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      lvl_d <= lvl;
      // any agreement with the accepted level restarts the stability window
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // key_n is active-low: only the accepted 1->0 step is a press
  assign press = lvl_d & ~lvl;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: purchase result / self-test indication FSM with a
// timed auto-return to idle and registered mode/busy outputs.
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = 1000000,
  parameter int HOLD_CYCLES = 150000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_n,
  input  logic       buy_ok,
  input  logic       buy_fail,
  output logic [2:0] mode,
  output logic       busy
);

  logic             press;
  logic [1:0]       state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             tmr_clr;
  logic             showing;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
    .clk   (clk),
    .rstn  (rstn),
    .key_n (key_n),
    .press (press)
  );

  assign showing = (state == ST_SUCCESS) || (state == ST_FAIL);

  // priority: buy_fail > buy_ok > press > hold expiry, identical in every state
  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    if (buy_fail) begin
      state_nxt = ST_FAIL;
      tmr_clr   = 1'b1;
    end else if (buy_ok) begin
      state_nxt = ST_SUCCESS;
      tmr_clr   = 1'b1;
    end else if (press) begin
      state_nxt = (state == ST_IDLE) ? ST_TEST : ST_IDLE;
    end else if (showing && timer == TMR_W'(HOLD_CYCLES - 1)) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      mode  <= MODE_ON;
      busy  <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      mode  <= mode_of(state_nxt);
      busy  <= (state_nxt != ST_IDLE);
      if (tmr_clr)
        timer <= '0;
      else if (showing && timer != {TMR_W{1'b1}})
        timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl: directed scenarios then random
// key/purchase/reset traffic against a cycle-level reference model.
module tb_led_mode_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int MAXC = 8192;

  typedef enum int {M_IDLE, M_SUCC, M_FAIL, M_TEST} mst_t;
  typedef struct {
    logic [2:0] mode;
    logic       busy;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_n = 1'b1;
  logic       buy_ok = 1'b0;
  logic       buy_fail = 1'b0;
  logic [2:0] mode;
  logic       busy;

  led_mode_ctrl #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .key_n    (key_n),
    .buy_ok   (buy_ok),
    .buy_fail (buy_fail),
    .mode     (mode),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int   n = 0;
  bit   key_hist[0:MAXC-1];
  int   rst_idx = 0;
  bit   acc = 1'b1;
  bit   pend = 1'b0;
  mst_t st = M_IDLE;
  int   ent = 0;

  function automatic bit ksamp(input int i);
    if (i < 0 || i <= rst_idx) return 1'b1;
    return key_hist[i];
  endfunction

  task automatic model_reset();
    st      = M_IDLE;
    acc     = 1'b1;
    pend    = 1'b0;
    rst_idx = n;
  endtask

  task automatic model_edge(input bit ok, input bit fail, input bit press);
    if (fail) begin
      st = M_FAIL; ent = n;
    end else if (ok) begin
      st = M_SUCC; ent = n;
    end else if (press) begin
      st = (st == M_IDLE) ? M_TEST : M_IDLE;
    end else if ((st == M_SUCC || st == M_FAIL) && (n - ent) == HOLD) begin
      st = M_IDLE;
    end
  endtask

  // Advance one clock: model what the DUT sampled at this edge, then drive
  // the inputs for the next cycle and queue the expected outputs.
  task automatic step(input bit ok, input bit fail, input bit key, input bit rn);
    bit press, flip;
    exp_t e;
    @(posedge clk);
    #1;
    n++;
    key_hist[n] = rstn ? key_n : 1'b1;
    if (!rstn) begin
      model_reset();
    end else begin
      press = pend;
      pend  = 1'b0;
      // accepted level flips once DEB consecutive synchronized samples disagree
      flip = 1'b1;
      for (int i = n - 1 - DEB; i <= n - 2; i++)
        if (ksamp(i) == acc) flip = 1'b0;
      if (flip) begin
        acc = ~acc;
        if (!acc) pend = 1'b1;
      end
      model_edge(buy_ok, buy_fail, press);
    end
    buy_ok   = ok;
    buy_fail = fail;
    key_n    = key;
    rstn     = rn;
    if (!rn) model_reset();
    e.mode = (st == M_IDLE) ? 3'h3 : (st == M_SUCC) ? 3'h2 : 3'h1;
    e.busy = (st != M_IDLE);
    e.cyc  = n;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int cnt, input bit key);
    for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, key, 1'b1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (mode !== e.mode || busy !== e.busy) begin
        errors++;
        $display("FAIL cyc%0d mode/busy: got %0d/%0d expected %0d/%0d",
                 e.cyc, mode, busy, e.mode, e.busy);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit kr;
    int seg;
    bool_done_blk: begin end
    // reset held, then released with no stimulus
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(100, 1'b1);

    // buy_ok pulse -> slow blink for the full hold, then back to idle
    step(1'b1, 1'b0, 1'b1, 1'b1);
    idle(30, 1'b1);

    // short bounce ignored; long press enters TEST, second press leaves it
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(10, 1'b1);
    idle(10, 1'b0);
    idle(10, 1'b1);
    idle(10, 1'b0);
    idle(10, 1'b1);

    // simultaneous ok+fail -> FAIL; later buy_ok -> SUCCESS, hold restarts
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    idle(25, 1'b1);

    // in FAIL, press coincident with buy_ok wins as SUCCESS
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(pend, 1'b0, 1'b0, 1'b1);
    idle(8, 1'b1);
    idle(8, 1'b0);
    idle(10, 1'b1);

    // reset mid-SUCCESS, key held low across the reset release
    step(1'b1, 1'b0, 1'b1, 1'b1);
    idle(6, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(12, 1'b0);
    idle(30, 1'b1);

    // randomized traffic
    kr  = 1'b1;
    seg = 5;
    for (int i = 0; i < 2000; i++) begin
      bit ok, fl, rn;
      if (seg == 0) begin
        kr  = ~kr;
        seg = $urandom_range(1, 12);
      end
      seg--;
      ok = ($urandom_range(0, 39) == 0);
      fl = ($urandom_range(0, 59) == 0);
      rn = ($urandom_range(0, 499) != 0);
      step(ok & rn, fl & rn, kr, rn);
    end
    idle(5, 1'b1);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
